cal_wave_gen: RTL

//  Calibrated test-signal generator: the transmit-side counterpart of the scope measurement path.

---
 rtl/cal_wave_gen_pkg.sv | 28 ++
 rtl/cal_wave_gen_wave_shape.sv | 39 +++
 rtl/cal_wave_gen.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cal_wave_gen_pkg.sv
// Shared definitions for the calibrated wave generator: calibration defaults,
// waveform selector encodings and the configuration FSM state type.
package cal_wave_gen_pkg;

    // Calibration constants shared with the scope measurement path.
    localparam logic [11:0] DEF_VSEG = 12'd0;
    localparam logic [11:0] DEF_VMAX = 12'd3200;
    localparam logic [11:0] DEF_VMIN = 12'd1024;
    localparam logic [11:0] DEF_VMID = 12'd2055;

    // One voltage segment spans this many units of the measurement encoding.
    localparam int SEG_STEP = 100;

    typedef enum logic [1:0] {
        WAVE_SQUARE   = 2'd0,
        WAVE_TRIANGLE = 2'd1,
        WAVE_SAW      = 2'd2,
        WAVE_DC       = 2'd3
    } wave_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_CALC = 2'd2,
        ST_ARM  = 2'd3
    } gen_state_t;

endpackage

// File: rtl/cal_wave_gen_wave_shape.sv
// Phase-to-shape lookup: maps the top 12 phase bits and a waveform selector to
// a signed unit shape in -2048..+2048, registered once.
module cal_wave_gen_wave_shape
    import cal_wave_gen_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [11:0]        phase,
    input  logic [1:0]         wave_sel,
    output logic signed [12:0] shape
);

    logic signed [12:0] tri_ramp;
    logic signed [12:0] shape_calc;

    // Twice the position within the current half period, 0..4094.
    assign tri_ramp = $signed({1'b0, phase[10:0], 1'b0});

    always_comb begin
        shape_calc = 13'sd0;
        case (wave_sel_t'(wave_sel))
            WAVE_SQUARE:   shape_calc = phase[11] ? -13'sd2048 : 13'sd2048;
            WAVE_TRIANGLE: shape_calc = phase[11] ? (13'sd2048 - tri_ramp)
                                                  : (tri_ramp - 13'sd2048);
            WAVE_SAW:      shape_calc = $signed({1'b0, phase}) - 13'sd2048;
            WAVE_DC:       shape_calc = 13'sd2048;
            default:       shape_calc = 13'sd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shape <= 13'sd0;
        end else begin
            shape <= shape_calc;
        end
    end

endmodule

// File: rtl/cal_wave_gen.sv
// Calibrated test-signal generator: converts a requested peak voltage into a
// DAC amplitude via the segment table, then synthesises a scaled waveform.
module cal_wave_gen
    import cal_wave_gen_pkg::*;
#(
    parameter logic [11:0] V1      = DEF_VSEG,
    parameter logic [11:0] V2      = DEF_VSEG,
    parameter logic [11:0] V3      = DEF_VSEG,
    parameter logic [11:0] V4      = DEF_VSEG,
    parameter logic [11:0] V5      = DEF_VSEG,
    parameter logic [11:0] V6      = DEF_VSEG,
    parameter logic [11:0] V7      = DEF_VSEG,
    parameter logic [11:0] V8      = DEF_VSEG,
    parameter logic [11:0] V9      = DEF_VSEG,
    parameter logic [11:0] V10     = DEF_VSEG,
    parameter logic [11:0] VMAX    = DEF_VMAX,
    parameter logic [11:0] VMIN    = DEF_VMIN,
    parameter logic [11:0] VMID    = DEF_VMID,
    parameter int          PHASE_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [10:0]        cfg_v,
    input  logic [PHASE_W-1:0] cfg_fre,
    input  logic [1:0]         cfg_wave,
    output logic [11:0]        dac_data,
    output logic               dac_valid,
    output logic               period_sync,
    output logic               busy,
    output gen_state_t         dbg_state
);

    // Handshake: a config transfers on a rising clk edge where cfg_valid and
    // cfg_ready are both high; cfg_ready is high only while the FSM is idle,
    // and cfg_* are don't-care whenever cfg_valid is low.

    localparam logic [10:0] STEP = 11'(SEG_STEP);

    gen_state_t state, state_nxt;
    logic xfer, div_step, commit;

    logic [10:0]        v_lat;
    logic [PHASE_W-1:0] fre_lat;
    logic [1:0]         wave_lat;
    logic [10:0]        rem;
    logic [4:0]         quo;
    logic [11:0]        amp_pend;

    logic [11:0]        amp_act;
    logic [PHASE_W-1:0] fre_act;
    logic [1:0]         wave_act;

    logic [PHASE_W-1:0] ph, ph_sum;
    logic               wrap;

    logic [11:0]        seg_base;
    logic [13:0]        peak_raw;
    logic [11:0]        peak;
    logic [11:0]        amp_calc;

    logic signed [12:0] shape_s1;
    logic [11:0]        amp_s1;
    logic signed [25:0] shape_ext, amp_ext;
    logic signed [25:0] prod_s2;
    logic signed [25:0] scaled, out_calc;
    logic [11:0]        out_clip;
    logic [2:0]         vld_sr;

    assign cfg_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    // Next state and per-cycle strobes.
    always_comb begin
        state_nxt = state;
        xfer      = 1'b0;
        div_step  = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_valid) begin
                    xfer      = 1'b1;
                    state_nxt = ST_DIV;
                end
            end
            ST_DIV: begin
                if (rem >= STEP) begin
                    div_step = 1'b1;
                end else begin
                    state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                state_nxt = ST_ARM;
            end
            ST_ARM: begin
                // A stopped accumulator never wraps, so apply straight away.
                if (wrap || (fre_act == '0)) begin
                    commit    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Segment table lookup; segment 0 starts at the zero-volt code.
    always_comb begin
        seg_base = V10;
        case (quo)
            5'd0:    seg_base = VMID;
            5'd1:    seg_base = V1;
            5'd2:    seg_base = V2;
            5'd3:    seg_base = V3;
            5'd4:    seg_base = V4;
            5'd5:    seg_base = V5;
            5'd6:    seg_base = V6;
            5'd7:    seg_base = V7;
            5'd8:    seg_base = V8;
            5'd9:    seg_base = V9;
            default: seg_base = V10;
        endcase
    end

    always_comb begin
        peak_raw = {2'b00, V10};
        if (quo <= 5'd9) begin
            peak_raw = {2'b00, seg_base} + {3'b000, rem};
        end else if (quo == 5'd10) begin
            peak_raw = {2'b00, V10};
        end else begin
            // Above the table the last segment's slope is extrapolated 1:1.
            peak_raw = {2'b00, V10} + {3'b000, v_lat - 11'd1100};
        end
        peak = peak_raw[11:0];
        if (peak_raw < {2'b00, VMID}) begin
            peak = VMID;
        end else if (peak_raw > {2'b00, VMAX}) begin
            peak = VMAX;
        end
        amp_calc = peak - VMID;
    end

    // Config latch, divider and pending amplitude.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_lat    <= '0;
            fre_lat  <= '0;
            wave_lat <= '0;
            rem      <= '0;
            quo      <= '0;
            amp_pend <= '0;
        end else begin
            if (xfer) begin
                v_lat    <= cfg_v;
                fre_lat  <= cfg_fre;
                wave_lat <= cfg_wave;
                rem      <= cfg_v;
                quo      <= '0;
            end else if (div_step) begin
                rem <= rem - STEP;
                quo <= quo + 5'd1;
            end
            if (state == ST_CALC) begin
                amp_pend <= amp_calc;
            end
        end
    end

    // Active configuration only changes on a period boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            amp_act  <= '0;
            fre_act  <= '0;
            wave_act <= '0;
        end else if (commit) begin
            amp_act  <= amp_pend;
            fre_act  <= fre_lat;
            wave_act <= wave_lat;
        end
    end

    assign {wrap, ph_sum} = {1'b0, ph} + {1'b0, fre_act};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph          <= '0;
            period_sync <= 1'b0;
        end else begin
            ph          <= ph_sum;
            period_sync <= wrap;
        end
    end

    cal_wave_gen_wave_shape u_wave_shape (
        .clk      (clk),
        .rst      (rst),
        .phase    (ph[PHASE_W-1 -: 12]),
        .wave_sel (wave_act),
        .shape    (shape_s1)
    );

    // Amplitude travels with its shape sample so a commit never splits a sample.
    assign shape_ext = {{13{shape_s1[12]}}, shape_s1};
    assign amp_ext   = {14'b0, amp_s1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            amp_s1  <= '0;
            prod_s2 <= '0;
        end else begin
            amp_s1  <= amp_act;
            prod_s2 <= shape_ext * amp_ext;
        end
    end

    always_comb begin
        scaled   = prod_s2 >>> 11;
        out_calc = scaled + $signed({14'b0, VMID});
        out_clip = out_calc[11:0];
        if (out_calc < $signed({14'b0, VMIN})) begin
            out_clip = VMIN;
        end else if (out_calc > $signed({14'b0, VMAX})) begin
            out_clip = VMAX;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dac_data <= VMID;
            vld_sr   <= '0;
        end else begin
            dac_data <= out_clip;
            vld_sr   <= {vld_sr[1:0], 1'b1};
        end
    end

    assign dac_valid = vld_sr[2];

endmodule
